pmu_event_counter_bank: RTL and testbench
=========================================

Name: pmu_event_counter_bank

Overview:
- Downstream consumer of the PMU 2-stage event synchronizers.
- Takes already-synchronized event bits in the PMU clock domain and counts them per event, in either edge or level mode.
- Provides wrapping counters with sticky overflow flags, a registered overflow interrupt, and a one-cycle-latency read port for the PMU register front-end.

Parameters:
- NUM_EVENTS, 8: number of independent event counters (1..32).
- CNT_WIDTH, 64: counter width in bits (8..64).
- IDX_WIDTH, $clog2(NUM_EVENTS) with a minimum of 1: width of the read index.

Ports:
- clk  in  1  PMU clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- event_sync_i  in  NUM_EVENTS  synchronized event levels, one bit per event.
- cfg_en_i  in  NUM_EVENTS  per-event count enable.
- cfg_edge_i  in  NUM_EVENTS  1 = count rising edges; 0 = count cycles while high.
- clr_i  in  NUM_EVENTS  per-event clear pulse; clears the counter and its overflow flag.
- rd_req_i  in  1  read request; one request per cycle allowed.
- rd_idx_i  in  IDX_WIDTH  counter index to read.
- rd_ack_o  out  1  read response valid.
- rd_data_o  out  CNT_WIDTH  read data.
- ovf_o  out  NUM_EVENTS  sticky per-event overflow flags.
- irq_o  out  1  registered OR of (ovf_o & cfg_en_i).

Behaviour:
- Reset (rst=1 at a clk edge): all counters 0, prev-event register 0, ovf_o 0, irq_o 0, rd_ack_o 0, rd_data_o 0.
- Reset takes effect mid-operation at the next edge and overrides every other input.
- Edge detect: prev[i] <= event_sync_i[i] every cycle, regardless of cfg_en_i. Enabling while an event is already high therefore creates no phantom edge.
- Increment condition: inc[i] = cfg_en_i[i] & (cfg_edge_i[i] ? (event_sync_i[i] & ~prev[i]) : event_sync_i[i]).
- Counter update: cnt[i] <= cnt[i] + 1 when inc[i]. Latency is one cycle from sampled event to updated count.
- Wrap-around: when cnt[i] is all ones and inc[i] is set, cnt[i] becomes 0 and ovf_o[i] is set. ovf_o[i] stays set until clr_i[i] or rst.
- Clear priority: clr_i[i] in the same cycle as inc[i] gives cnt[i]=0 and ovf_o[i]=0; the increment is dropped.
- Clear also overrides a wrap in that cycle, so ovf_o[i] stays 0.
- cfg_edge_i change: the next cycle uses the new mode. prev is unaffected.
- Read:
  - rd_req_i=1 at edge N gives rd_ack_o=1 at edge N+1.
  - rd_data_o is the counter value held before edge N, i.e. it excludes any increment occurring at edge N.
  - Back-to-back requests are acknowledged back-to-back.
  - rd_ack_o=0 in cycles without a preceding request; rd_data_o holds its last value.
  - rd_idx_i >= NUM_EVENTS returns rd_data_o=0 with rd_ack_o=1.
- irq_o: registered; rises one cycle after the ovf_o bit sets, and falls one cycle after the flag clears or the enable drops.
- No backpressure: the read consumer must always accept rd_ack_o.

Decomposition:
- Package pmu_pkg holds:
  - localparam PMU_MAX_EVENTS = 32;
  - typedef cnt_t (logic [CNT_WIDTH-1:0]);
  - function next_count(cnt, inc, clr), returning the {ovf_set, cnt_next} pair.
- Sub-module pmu_event_counter: one slice containing the edge-detect flop, the counter and the sticky overflow flag.
- The top generates NUM_EVENTS slices and adds the read mux/register and the irq register.

Test Plan:
- Level mode, en=1: hold event0 high for 5 cycles, then read idx 0 → rd_ack one cycle later with rd_data=5.
- Edge mode: 3 pulses of 2 cycles each on event1, then enable with event1 already high followed by 1 more pulse → count=4 (not 5), read returns 4.
- Wrap: CNT_WIDTH=8, count 256 level-mode cycles → cnt=0, ovf_o[0]=1, irq_o=1 one cycle later; clr_i[0] → ovf_o[0]=0, irq_o=0 the cycle after.
- Simultaneous events: clr_i[2] with inc[2] at cnt=0xFF (CNT_WIDTH=8) → cnt=0, ovf_o[2]=0. Read request in the same cycle as an increment returns the pre-increment value.
- Reads: back-to-back requests to idx 0,1,7 return the three values on consecutive acks; idx=8 (NUM_EVENTS=8, IDX_WIDTH=4) → rd_data=0 with ack.
- Reset mid-count: counters at 17/42, assert rst for 1 cycle → all counters, ovf_o, irq_o and rd_ack_o are 0; counting resumes the cycle after rst deasserts.

Source files
------------

// File: rtl/pmu_pkg.sv
// Shared types and the per-counter next-state function for the PMU event counter bank.
package pmu_pkg;

  localparam int PMU_MAX_EVENTS    = 32;
  localparam int PMU_MAX_CNT_WIDTH = 64;

  // Widest supported counter; narrower slices zero-extend into it and truncate back.
  typedef logic [PMU_MAX_CNT_WIDTH-1:0] cnt_t;

  typedef struct packed {
    logic ovf_set;
    cnt_t cnt_next;
  } cnt_upd_t;

  // Clear wins over increment and suppresses the overflow of a coincident wrap.
  function automatic cnt_upd_t next_count(input cnt_t cnt, input cnt_t cnt_max,
                                          input logic inc, input logic clr);
    cnt_upd_t r;
    r.ovf_set  = 1'b0;
    r.cnt_next = cnt;
    if (clr) begin
      r.cnt_next = '0;
    end else if (inc) begin
      if (cnt == cnt_max) begin
        r.cnt_next = '0;
        r.ovf_set  = 1'b1;
      end else begin
        r.cnt_next = cnt + cnt_t'(1);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/pmu_event_counter_bank_counter.sv
// One event slice: edge-detect flop, wrapping counter and sticky overflow flag.
module pmu_event_counter
  import pmu_pkg::*;
#(
  parameter int CNT_WIDTH = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 event_i,
  input  logic                 en_i,
  input  logic                 edge_i,
  input  logic                 clr_i,
  output logic [CNT_WIDTH-1:0] cnt_o,
  output logic                 ovf_o
);

  logic                 prev_q, prev_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 ovf_q, ovf_d;
  logic                 inc;
  cnt_upd_t             upd;

  always_comb begin
    // prev tracks the event even while disabled so enabling on a high level is not an edge.
    prev_d = event_i;
    inc    = en_i & (edge_i ? (event_i & ~prev_q) : event_i);
    upd    = next_count(cnt_t'(cnt_q), cnt_t'({CNT_WIDTH{1'b1}}), inc, clr_i);
    cnt_d  = upd.cnt_next[CNT_WIDTH-1:0];
    ovf_d  = ~clr_i & (ovf_q | upd.ovf_set);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_q <= 1'b0;
      cnt_q  <= '0;
      ovf_q  <= 1'b0;
    end else begin
      prev_q <= prev_d;
      cnt_q  <= cnt_d;
      ovf_q  <= ovf_d;
    end
  end

  assign cnt_o = cnt_q;
  assign ovf_o = ovf_q;

endmodule

// File: rtl/pmu_event_counter_bank.sv
// Bank of per-event counters with a registered read port and a registered overflow interrupt.
module pmu_event_counter_bank
  import pmu_pkg::*;
#(
  parameter int NUM_EVENTS = 8,
  parameter int CNT_WIDTH  = 64,
  parameter int IDX_WIDTH  = (NUM_EVENTS > 1) ? $clog2(NUM_EVENTS) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_EVENTS-1:0] event_sync_i,
  input  logic [NUM_EVENTS-1:0] cfg_en_i,
  input  logic [NUM_EVENTS-1:0] cfg_edge_i,
  input  logic [NUM_EVENTS-1:0] clr_i,
  input  logic                  rd_req_i,
  input  logic [IDX_WIDTH-1:0]  rd_idx_i,
  output logic                  rd_ack_o,
  output logic [CNT_WIDTH-1:0]  rd_data_o,
  output logic [NUM_EVENTS-1:0] ovf_o,
  output logic                  irq_o
);

  logic [NUM_EVENTS-1:0][CNT_WIDTH-1:0] cnt_all;
  logic [NUM_EVENTS-1:0]                ovf_all;

  for (genvar g = 0; g < NUM_EVENTS; g++) begin : g_slice
    pmu_event_counter #(
      .CNT_WIDTH (CNT_WIDTH)
    ) u_cnt (
      .clk     (clk),
      .rst     (rst),
      .event_i (event_sync_i[g]),
      .en_i    (cfg_en_i[g]),
      .edge_i  (cfg_edge_i[g]),
      .clr_i   (clr_i[g]),
      .cnt_o   (cnt_all[g]),
      .ovf_o   (ovf_all[g])
    );
  end

  logic                 rd_ack_q, rd_ack_d;
  logic [CNT_WIDTH-1:0] rd_data_q, rd_data_d;
  logic                 irq_q, irq_d;
  logic [CNT_WIDTH-1:0] rd_sel;

  always_comb begin
    // Out-of-range indices match no slice and read back as zero.
    rd_sel = '0;
    for (int i = 0; i < NUM_EVENTS; i++) begin
      if (rd_idx_i == IDX_WIDTH'(i)) rd_sel = cnt_all[i];
    end
    rd_ack_d  = rd_req_i;
    rd_data_d = rd_req_i ? rd_sel : rd_data_q;
    irq_d     = |(ovf_all & cfg_en_i);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ack_q  <= 1'b0;
      rd_data_q <= '0;
      irq_q     <= 1'b0;
    end else begin
      rd_ack_q  <= rd_ack_d;
      rd_data_q <= rd_data_d;
      irq_q     <= irq_d;
    end
  end

  assign rd_ack_o  = rd_ack_q;
  assign rd_data_o = rd_data_q;
  assign ovf_o     = ovf_all;
  assign irq_o     = irq_q;

endmodule

// File: tb/tb_pmu_event_counter_bank.sv
// Directed vector bench for pmu_event_counter_bank (8 events, 8-bit counters, 4-bit read index).
module tb_pmu_event_counter_bank;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] ev, en, ed, clr;
  logic       rq;
  logic [3:0] idx;
  logic       ack;
  logic [7:0] data;
  logic [7:0] ovf;
  logic       irq;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  pmu_event_counter_bank #(
    .NUM_EVENTS (8),
    .CNT_WIDTH  (8),
    .IDX_WIDTH  (4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .event_sync_i (ev),
    .cfg_en_i     (en),
    .cfg_edge_i   (ed),
    .clr_i        (clr),
    .rd_req_i     (rq),
    .rd_idx_i     (idx),
    .rd_ack_o     (ack),
    .rd_data_o    (data),
    .ovf_o        (ovf),
    .irq_o        (irq)
  );

  typedef struct {
    logic [7:0] ev, en, ed, clr;
    logic       rq;
    logic [3:0] idx;
    logic       ack;
    logic [7:0] data, ovf;
    logic       irq;
  } vec_t;

  vec_t vecs[$];

  task automatic add_v(input logic [7:0] v_ev, v_en, v_ed, v_clr, input logic v_rq,
                       input logic [3:0] v_idx, input logic v_ack, input logic [7:0] v_data,
                       input logic [7:0] v_ovf, input logic v_irq);
    vec_t v;
    v.ev = v_ev; v.en = v_en; v.ed = v_ed; v.clr = v_clr; v.rq = v_rq; v.idx = v_idx;
    v.ack = v_ack; v.data = v_data; v.ovf = v_ovf; v.irq = v_irq;
    vecs.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // One clock: drive inputs, take the edge, settle 1 time unit past it.
  task automatic cyc(input logic [7:0] c_ev, c_en, c_ed, c_clr, input logic c_rq,
                     input logic [3:0] c_idx);
    ev = c_ev; en = c_en; ed = c_ed; clr = c_clr; rq = c_rq; idx = c_idx;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string nm, input logic e_ack, input logic [7:0] e_data,
                         input logic [7:0] e_ovf, input logic e_irq);
    chk({nm, ".ack"},  64'(ack),  64'(e_ack));
    chk({nm, ".data"}, 64'(data), 64'(e_data));
    chk({nm, ".ovf"},  64'(ovf),  64'(e_ovf));
    chk({nm, ".irq"},  64'(irq),  64'(e_irq));
  endtask

  initial begin
    rst = 1'b1;
    cyc(8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 4'd0);
    cyc(8'h00, 8'h00, 8'h00, 8'h00, 1'b1, 4'd0);
    chk_out("reset", 1'b0, 8'h00, 8'h00, 1'b0);
    rst = 1'b0;

    // Level mode on event 0: five high cycles then read.
    for (int k = 0; k < 5; k++) add_v(8'h01, 8'h03, 8'h02, 8'h00, 1'b0, 4'd0, 1'b0, 8'h00, 8'h00, 1'b0);
    add_v(8'h00, 8'h03, 8'h02, 8'h00, 1'b1, 4'd0, 1'b1, 8'h05, 8'h00, 1'b0);
    add_v(8'h00, 8'h03, 8'h02, 8'h00, 1'b0, 4'd0, 1'b0, 8'h05, 8'h00, 1'b0);
    // Edge mode on event 1: three 2-cycle pulses.
    for (int p = 0; p < 3; p++) begin
      add_v(8'h02, 8'h03, 8'h02, 8'h00, 1'b0, 4'd0, 1'b0, 8'h05, 8'h00, 1'b0);
      add_v(8'h02, 8'h03, 8'h02, 8'h00, 1'b0, 4'd0, 1'b0, 8'h05, 8'h00, 1'b0);
      add_v(8'h00, 8'h03, 8'h02, 8'h00, 1'b0, 4'd0, 1'b0, 8'h05, 8'h00, 1'b0);
    end
    // Rise while disabled, enable while high: no phantom edge; then one real pulse.
    add_v(8'h02, 8'h01, 8'h02, 8'h00, 1'b0, 4'd0, 1'b0, 8'h05, 8'h00, 1'b0);
    add_v(8'h02, 8'h03, 8'h02, 8'h00, 1'b0, 4'd0, 1'b0, 8'h05, 8'h00, 1'b0);
    add_v(8'h00, 8'h03, 8'h02, 8'h00, 1'b0, 4'd0, 1'b0, 8'h05, 8'h00, 1'b0);
    add_v(8'h02, 8'h03, 8'h02, 8'h00, 1'b0, 4'd0, 1'b0, 8'h05, 8'h00, 1'b0);
    add_v(8'h00, 8'h03, 8'h02, 8'h00, 1'b1, 4'd1, 1'b1, 8'h04, 8'h00, 1'b0);
    // Edge count then switch to level mid-high: 4 -> 5 -> 6 -> 7.
    add_v(8'h02, 8'h03, 8'h02, 8'h00, 1'b0, 4'd0, 1'b0, 8'h04, 8'h00, 1'b0);
    add_v(8'h02, 8'h03, 8'h00, 8'h00, 1'b0, 4'd0, 1'b0, 8'h04, 8'h00, 1'b0);
    add_v(8'h02, 8'h03, 8'h00, 8'h00, 1'b0, 4'd0, 1'b0, 8'h04, 8'h00, 1'b0);
    add_v(8'h00, 8'h03, 8'h02, 8'h00, 1'b1, 4'd1, 1'b1, 8'h07, 8'h00, 1'b0);
    // Back-to-back reads 0,1,7, out-of-range 8, then 0 again, then idle hold.
    add_v(8'h00, 8'h03, 8'h02, 8'h00, 1'b1, 4'd0, 1'b1, 8'h05, 8'h00, 1'b0);
    add_v(8'h00, 8'h03, 8'h02, 8'h00, 1'b1, 4'd1, 1'b1, 8'h07, 8'h00, 1'b0);
    add_v(8'h00, 8'h03, 8'h02, 8'h00, 1'b1, 4'd7, 1'b1, 8'h00, 8'h00, 1'b0);
    add_v(8'h00, 8'h03, 8'h02, 8'h00, 1'b1, 4'd8, 1'b1, 8'h00, 8'h00, 1'b0);
    add_v(8'h00, 8'h03, 8'h02, 8'h00, 1'b1, 4'd0, 1'b1, 8'h05, 8'h00, 1'b0);
    add_v(8'h00, 8'h03, 8'h02, 8'h00, 1'b0, 4'd0, 1'b0, 8'h05, 8'h00, 1'b0);
    // Read in the same cycle as an increment returns the pre-increment value.
    add_v(8'h01, 8'h03, 8'h02, 8'h00, 1'b1, 4'd0, 1'b1, 8'h05, 8'h00, 1'b0);
    add_v(8'h00, 8'h03, 8'h02, 8'h00, 1'b1, 4'd0, 1'b1, 8'h06, 8'h00, 1'b0);
    add_v(8'h00, 8'h03, 8'h02, 8'h00, 1'b0, 4'd0, 1'b0, 8'h06, 8'h00, 1'b0);

    foreach (vecs[i]) begin
      cyc(vecs[i].ev, vecs[i].en, vecs[i].ed, vecs[i].clr, vecs[i].rq, vecs[i].idx);
      chk_out($sformatf("vec%0d", i), vecs[i].ack, vecs[i].data, vecs[i].ovf, vecs[i].irq);
    end

    // Wrap on event 0: 256 level cycles, last one read in flight.
    cyc(8'h00, 8'h01, 8'h00, 8'hff, 1'b0, 4'd0);
    for (int k = 0; k < 255; k++) cyc(8'h01, 8'h01, 8'h00, 8'h00, 1'b0, 4'd0);
    cyc(8'h01, 8'h01, 8'h00, 8'h00, 1'b1, 4'd0);
    chk_out("wrap_edge", 1'b1, 8'hff, 8'h01, 1'b0);
    cyc(8'h00, 8'h01, 8'h00, 8'h00, 1'b1, 4'd0);
    chk_out("wrap_irq", 1'b1, 8'h00, 8'h01, 1'b1);
    cyc(8'h00, 8'h01, 8'h00, 8'h01, 1'b0, 4'd0);
    chk_out("wrap_clr", 1'b0, 8'h00, 8'h00, 1'b1);
    cyc(8'h00, 8'h01, 8'h00, 8'h00, 1'b0, 4'd0);
    chk_out("wrap_irq_fall", 1'b0, 8'h00, 8'h00, 1'b0);

    // Clear coinciding with a wrapping increment on event 2.
    for (int k = 0; k < 255; k++) cyc(8'h04, 8'h04, 8'h00, 8'h00, 1'b0, 4'd0);
    cyc(8'h04, 8'h04, 8'h00, 8'h04, 1'b1, 4'd2);
    chk_out("clr_wrap", 1'b1, 8'hff, 8'h00, 1'b0);
    cyc(8'h00, 8'h04, 8'h00, 8'h00, 1'b1, 4'd2);
    chk_out("clr_wrap_rd", 1'b1, 8'h00, 8'h00, 1'b0);

    // Reset mid-count: counters 17/42 and event 2 wrapped with irq raised.
    cyc(8'h00, 8'h07, 8'h00, 8'hff, 1'b0, 4'd0);
    for (int k = 1; k <= 256; k++)
      cyc({5'b0, 1'b1, (k <= 42), (k <= 17)}, 8'h07, 8'h00, 8'h00, 1'b0, 4'd0);
    cyc(8'h00, 8'h07, 8'h00, 8'h00, 1'b1, 4'd0);
    chk_out("pre_rst0", 1'b1, 8'd17, 8'h04, 1'b1);
    cyc(8'h00, 8'h07, 8'h00, 8'h00, 1'b1, 4'd1);
    chk_out("pre_rst1", 1'b1, 8'd42, 8'h04, 1'b1);
    rst = 1'b1;
    cyc(8'h07, 8'h07, 8'h00, 8'h00, 1'b1, 4'd1);
    chk_out("mid_rst", 1'b0, 8'h00, 8'h00, 1'b0);
    rst = 1'b0;
    cyc(8'h01, 8'h07, 8'h00, 8'h00, 1'b0, 4'd0);
    cyc(8'h00, 8'h07, 8'h00, 8'h00, 1'b1, 4'd0);
    chk_out("post_rst0", 1'b1, 8'd1, 8'h00, 1'b0);
    cyc(8'h00, 8'h07, 8'h00, 8'h00, 1'b1, 4'd1);
    chk_out("post_rst1", 1'b1, 8'd0, 8'h00, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
